// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, NB_STOP-times oversampling, LSB-first framing with 1 stop bit.
// Define UART_RX_PARITY_EN to add the parity bit state and the o_parity_err output.
module uart_rx #(
  parameter int NB_DATA    = 8,
  parameter int NB_STOP    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rxdone,
`ifdef UART_RX_PARITY_EN
  output logic               o_parity_err,
`endif
  output logic               o_frame_err
);

  // Number of bits needed to hold value; never narrower than one bit.
  function automatic int clogb2(input int value);
    int width;
    int v;
    width = 0;
    v     = value;
    while (v > 0) begin
      width = width + 1;
      v     = v >> 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

  localparam int TW = clogb2(NB_STOP - 1);
  localparam int BW = clogb2(NB_DATA - 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(NB_STOP / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(NB_STOP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  if ((NB_STOP < 4) || (NB_STOP % 2 != 0) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_params
    $error("uart_rx: NB_STOP must be even and >= 4, PARITY_ODD must be 0 or 1");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    START   = 5'b00010,
    RECEIVE = 5'b00100,
    PARITY  = 5'b01000,
    STOP    = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    START   = 4'b0010,
    RECEIVE = 4'b0100,
    STOP    = 4'b1000
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_d;
  logic               frame_err_d;
  logic               rxdone_d;
  logic               rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_d;
  logic               parity_err_d;
`endif

  // NOTE: the synchronizer resets to 1 (line idle) so that leaving reset
  // never looks like a falling start edge.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: every register uses non-blocking assignment so all flops update
  // together from the values computed before the edge.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      o_data       <= '0;
      o_rxdone     <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      o_data       <= data_d;
      o_rxdone     <= rxdone_d;
      o_frame_err  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      o_parity_err <= parity_err_d;
`endif
    end
  end

  always_comb begin
    // NOTE: each output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_d       = o_data;
    frame_err_d  = o_frame_err;
    rxdone_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = o_parity_err;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (tick_q == TICK_MID) begin
            if (!rx_s) begin
              state_d = RECEIVE;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      RECEIVE: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[NB_DATA-1:1]};
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            par_d   = rx_s;
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            // A bad stop bit still delivers the byte; only the error flag marks it.
            data_d      = shift_q;
            frame_err_d = ~rx_s;
            rxdone_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ((^shift_q) ^ par_q) != 1'(PARITY_ODD);
`endif
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames checked against a frame-level model.
// Define UART_RX_PARITY_EN to also exercise the parity bit.
module tb_uart_rx;

  localparam int NB_DATA    = 8;
  localparam int NB_STOP    = 16;
  localparam int PARITY_ODD = 0;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLK    = NB_STOP * TICK_DIV;
  localparam int BAD_LOW    = 48;

  logic               clk = 1'b0;
  logic               i_rst_n;
  logic               i_tick;
  logic               i_rx;
  logic [NB_DATA-1:0] o_data;
  logic               o_rxdone;
  logic               o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic               o_parity_err;
`endif

  uart_rx #(
    .NB_DATA   (NB_DATA),
    .NB_STOP   (NB_STOP),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_rxdone    (o_rxdone),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    i_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    if (o_rxdone === 1'b1) begin
      rec_t r;
      r.data = o_data;
      r.ferr = o_frame_err;
`ifdef UART_RX_PARITY_EN
      r.perr = o_parity_err;
`else
      r.perr = 1'b0;
`endif
      got_q.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Parity bit that makes the frame correct for the configured sense.
  function automatic logic good_par(input logic [7:0] d);
    return 1'(($countones(d) + PARITY_ODD) % 2);
  endfunction

  // Frame-level model: the byte comes back as sent, a zero stop bit is a
  // framing error, and an odd/even ones count disagreeing with the sense is a parity error.
  task automatic expect_frame(input logic [7:0] d, input logic stop, input logic par);
    rec_t e;
    e.data = d;
    e.ferr = (stop == 1'b0);
`ifdef UART_RX_PARITY_EN
    e.perr = (($countones(d) + int'(par)) % 2) != PARITY_ODD;
`else
    e.perr = par & 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  // A bad stop bit is held low past its centre, then the line idles a full bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    i_rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < NB_DATA; i++) begin
      i_rx = d[i];
      wait_clk(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = par;
    wait_clk(BIT_CLK);
`endif
    if (stop) begin
      i_rx = 1'b1;
      wait_clk(BIT_CLK);
    end else begin
      i_rx = 1'b0;
      wait_clk(BAD_LOW);
      i_rx = 1'b1;
      wait_clk(BIT_CLK - BAD_LOW);
      wait_clk(BIT_CLK);
    end
  endtask

  task automatic compare_frames(input string tag);
    rec_t g;
    rec_t e;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(g.data), 32'(e.data));
      check({tag, "_ferr"}, 32'(g.ferr), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
      check({tag, "_perr"}, 32'(g.perr), 32'(e.perr));
`endif
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;
    logic [7:0] last_data;

    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    wait_clk(5);
    check("reset_data", 32'(o_data), 32'h0);
    check("reset_done", 32'(o_rxdone), 32'h0);
    check("reset_ferr", 32'(o_frame_err), 32'h0);
    i_rst_n = 1'b1;
    wait_clk(2 * BIT_CLK);

    // Clean 0xA5.
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    expect_frame(8'hA5, 1'b1, good_par(8'hA5));
    wait_clk(BIT_CLK);
    compare_frames("a5");
    check("a5_hold", 32'(o_data), 32'hA5);

    // Short low glitch on an idle line must be rejected at mid start bit.
    i_rx = 1'b0;
    wait_clk(5 * TICK_DIV);
    i_rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    compare_frames("glitch");
    check("glitch_data", 32'(o_data), 32'hA5);
    check("glitch_ferr", 32'(o_frame_err), 32'h0);

    // Bad stop bit, then a good frame clears the flag.
    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    expect_frame(8'h3C, 1'b0, good_par(8'h3C));
    compare_frames("badstop");
    check("badstop_hold", 32'(o_frame_err), 32'h1);
    send_frame(8'h11, 1'b1, good_par(8'h11));
    expect_frame(8'h11, 1'b1, good_par(8'h11));
    wait_clk(BIT_CLK);
    compare_frames("after_bad");
    check("after_bad_ferr", 32'(o_frame_err), 32'h0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, good_par(8'h00));
    send_frame(8'hFF, 1'b1, good_par(8'hFF));
    expect_frame(8'h00, 1'b1, good_par(8'h00));
    expect_frame(8'hFF, 1'b1, good_par(8'hFF));
    wait_clk(BIT_CLK);
    compare_frames("b2b");
    check("b2b_hold", 32'(o_data), 32'hFF);

    // Reset in the middle of data bit 4 of 0x5A.
    d    = 8'h5A;
    i_rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      i_rx = d[i];
      wait_clk(BIT_CLK);
    end
    i_rx = d[4];
    wait_clk(BIT_CLK / 2);
    i_rst_n = 1'b0;
    wait_clk(3);
    check("midrst_data", 32'(o_data), 32'h0);
    check("midrst_done", 32'(o_rxdone), 32'h0);
    check("midrst_ferr", 32'(o_frame_err), 32'h0);
`ifdef UART_RX_PARITY_EN
    check("midrst_perr", 32'(o_parity_err), 32'h0);
`endif
    i_rx    = 1'b1;
    i_rst_n = 1'b1;
    wait_clk(2 * BIT_CLK);
    compare_frames("midrst");
    send_frame(8'h5A, 1'b1, good_par(8'h5A));
    expect_frame(8'h5A, 1'b1, good_par(8'h5A));
    wait_clk(BIT_CLK);
    compare_frames("after_rst");
    check("after_rst_data", 32'(o_data), 32'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame(8'h07, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    compare_frames("par_ok");
    check("par_ok_flag", 32'(o_parity_err), 32'(PARITY_ODD));
    send_frame(8'h07, 1'b1, 1'b0);
    expect_frame(8'h07, 1'b1, 1'b0);
    wait_clk(BIT_CLK);
    compare_frames("par_bad");
    check("par_bad_flag", 32'(o_parity_err), 32'(1 - PARITY_ODD));
`endif

    // Random frames with random stop bits, parity bits and idle gaps.
    last_data = 8'h5A;
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      par  = 1'($urandom_range(0, 1));
      send_frame(d, stop, par);
      expect_frame(d, stop, par);
      last_data = d;
      wait_clk(BIT_CLK * $urandom_range(0, 2));
    end
    wait_clk(BIT_CLK);
    compare_frames("random");
    check("random_hold", 32'(o_data), 32'(last_data));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
